// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer of {pc,inst} entries: up to two pushes and two pops per cycle,
// with the two oldest entries always visible to decode.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst,
  input  logic              in_inst2_valid,
  input  logic [31:0]       in_inst2,
  output logic              in_ready,
  output logic [1:0]        push_num,
  input  logic [1:0]        pop_num,
  output logic              out0_valid,
  output logic [31:0]       out0_pc,
  output logic [31:0]       out0_inst,
  output logic              out1_valid,
  output logic [31:0]       out1_pc,
  output logic [31:0]       out1_inst,
  output logic [PTR_W:0]    count
);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W:0]   free_slots;
  logic             push_ok;
  logic [1:0]       pop_eff;

  // Decode may ask for 3; it never gets more than 2, nor more than is held.
  function automatic logic [1:0] clamp_pop(input logic [1:0] req,
                                           input logic [PTR_W:0] held);
    logic [1:0] lim;
    lim = (req == 2'd3) ? 2'd2 : req;
    if (held < (PTR_W+1)'(lim))
      return held[1:0];
    return lim;
  endfunction

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  // Acceptance looks only at current occupancy, never at the same-cycle pop,
  // so in_ready has no combinational path from decode.
  assign free_slots = (PTR_W+1)'(DEPTH) - count;
  assign in_ready   = (free_slots >= (PTR_W+1)'(2));
  assign push_ok    = rst_n && in_valid && in_ready && !flush;
  assign push_num   = push_ok ? (in_inst2_valid ? 2'd2 : 2'd1) : 2'd0;
  assign pop_eff    = clamp_pop(pop_num, count);

  // Head and head+1 read straight from storage; zeroed when not occupied.
  always_comb begin
    out0_valid = (count >= (PTR_W+1)'(1));
    out1_valid = (count >= (PTR_W+1)'(2));
    out0_pc    = out0_valid ? pc_mem[head]      : 32'd0;
    out0_inst  = out0_valid ? inst_mem[head]    : 32'd0;
    out1_pc    = out1_valid ? pc_mem[head_p1]   : 32'd0;
    out1_inst  = out1_valid ? inst_mem[head_p1] : 32'd0;
  end

  // Pointer and occupancy update; flush outranks push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_eff);
      tail  <= tail + PTR_W'(push_num);
      count <= count + (PTR_W+1)'(push_num) - (PTR_W+1)'(pop_eff);
    end
  end

  // Entry storage; contents are left as-is on reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[tail]   <= in_pc;
      inst_mem[tail] <= in_inst;
      if (in_inst2_valid) begin
        pc_mem[tail_p1]   <= in_pc + 32'd4;
        inst_mem[tail_p1] <= in_inst2;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a queue-based reference of expected entries.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_inst2_valid;
  logic [31:0] in_inst2;
  logic        in_ready;
  logic [1:0]  push_num;
  logic [1:0]  pop_num;
  logic        out0_valid;
  logic [31:0] out0_pc;
  logic [31:0] out0_inst;
  logic        out1_valid;
  logic [31:0] out1_pc;
  logic [31:0] out1_inst;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;
  logic [63:0] q [$];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_inst2_valid(in_inst2_valid), .in_inst2(in_inst2),
    .in_ready(in_ready), .push_num(push_num), .pop_num(pop_num),
    .out0_valid(out0_valid), .out0_pc(out0_pc), .out0_inst(out0_inst),
    .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_inst(out1_inst),
    .count(count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},      64'(count),      64'(n));
    chk({tag, ".out0_valid"}, 64'(out0_valid), 64'(n >= 1));
    chk({tag, ".out0_pc"},    64'(out0_pc),    (n >= 1) ? 64'(q[0][63:32]) : 64'd0);
    chk({tag, ".out0_inst"},  64'(out0_inst),  (n >= 1) ? 64'(q[0][31:0])  : 64'd0);
    chk({tag, ".out1_valid"}, 64'(out1_valid), 64'(n >= 2));
    chk({tag, ".out1_pc"},    64'(out1_pc),    (n >= 2) ? 64'(q[1][63:32]) : 64'd0);
    chk({tag, ".out1_inst"},  64'(out1_inst),  (n >= 2) ? 64'(q[1][31:0])  : 64'd0);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] i1,
                       input logic v2, input logic [31:0] i2, input logic [1:0] p,
                       input logic f);
    in_valid       = v;
    in_pc          = pc;
    in_inst        = i1;
    in_inst2_valid = v2;
    in_inst2       = i2;
    pop_num        = p;
    flush          = f;
  endtask

  // One clock: check the combinational handshake, clock it, update the model, check state.
  task automatic step(input string tag);
    int n;
    int pe;
    logic rdy;
    logic acc;
    logic [1:0] epn;
    n   = q.size();
    rdy = ((8 - n) >= 2);
    acc = in_valid && rdy && !flush;
    epn = acc ? (in_inst2_valid ? 2'd2 : 2'd1) : 2'd0;
    pe  = (pop_num == 2'd3) ? 2 : int'(pop_num);
    if (pe > n) pe = n;
    #1;
    chk({tag, ".push_num"}, 64'(push_num), 64'(epn));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      for (int k = 0; k < pe; k++) q.delete(0);
      if (acc) begin
        q.push_back({in_pc, in_inst});
        if (in_inst2_valid) q.push_back({in_pc + 32'd4, in_inst2});
      end
    end
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'h0000_1234, 32'hAAAA_0000, 1'b1, 32'hBBBB_0000, 2'd0, 1'b0);
    #2;
    chk("reset.push_num", 64'(push_num), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    check_state("reset");
    #10;
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check_state("post_reset");

    // First pair push
    drive(1'b1, 32'h8000_0000, 32'h1111_1111, 1'b1, 32'h2222_2222, 2'd0, 1'b0);
    step("pair0");

    // Fill to capacity
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 32'h8000_0000 + 32'(8 * k), 32'h1111_0000 + 32'(k),
            1'b1, 32'h2222_0000 + 32'(k), 2'd0, 1'b0);
      step("fill");
    end
    drive(1'b1, 32'h9000_0000, 32'hDEAD_0001, 1'b1, 32'hDEAD_0002, 2'd0, 1'b0);
    step("full_hold");

    // Down to 7, then single pushes that must be refused
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd1, 1'b0);
    step("pop1_to7");
    drive(1'b1, 32'h9100_0000, 32'hDEAD_0003, 1'b0, 32'd0, 2'd0, 1'b0);
    step("c7_nopop");
    drive(1'b1, 32'h9200_0000, 32'hDEAD_0004, 1'b0, 32'd0, 2'd2, 1'b0);
    step("c7_pop2");

    // To 6, then push2/pop2 pairs that walk pointers across the wrap
    drive(1'b1, 32'hA000_0000, 32'h3333_0000, 1'b0, 32'd0, 2'd0, 1'b0);
    step("c5_push1");
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hB000_0000 + 32'(16 * k), 32'h4444_0000 + 32'(k),
            1'b1, 32'h5555_0000 + 32'(k), 2'd2, 1'b0);
      step("c6_push2pop2");
    end

    // Drain, ending with an over-sized pop request
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd2, 1'b0);
    step("drain2");
    step("drain2");
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd1, 1'b0);
    step("drain1");
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd3, 1'b0);
    step("pop3_c1");

    // Build to 5, then flush against push and pop
    drive(1'b1, 32'hC000_0000, 32'h6666_0001, 1'b1, 32'h6666_0002, 2'd0, 1'b0);
    step("refill");
    drive(1'b1, 32'hC000_0008, 32'h6666_0003, 1'b1, 32'h6666_0004, 2'd0, 1'b0);
    step("refill");
    drive(1'b1, 32'hC000_0010, 32'h6666_0005, 1'b0, 32'd0, 2'd0, 1'b0);
    step("refill");
    drive(1'b1, 32'hD000_0000, 32'h7777_0001, 1'b1, 32'h7777_0002, 2'd2, 1'b1);
    step("flush");

    // Asynchronous reset in the middle of traffic
    drive(1'b1, 32'hE000_0000, 32'h8888_0001, 1'b1, 32'h8888_0002, 2'd0, 1'b0);
    step("pre_areset");
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("areset.push_num", 64'(push_num), 64'd0);
    chk("areset.in_ready", 64'(in_ready), 64'd1);
    check_state("areset");
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'hF000_0000, 32'h9999_0001, 1'b0, 32'd0, 2'd0, 1'b0);
    step("post_areset");
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b0);
    step("idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
